count_game_ctrl: RTL and testbench
==================================

# count_game_ctrl

Round controller for the counting game. It free-runs the 7-bit random generator while idle and freezes it on a start press. It then latches a target in 0..99 and runs a visible count at a prescaled tick rate. It grades the player's hit press against the target and keeps a saturating score. It sits between the debounced key inputs and the display/score logic, and owns the generator's `st` enable.

## Interface
- `TICK_DIV`, 5_000_000: clk cycles per count tick (≥2).
- `MAX_COUNT`, 99: last count value before timeout (≥99, ≤127).
- `TOL`, 2: max |count−target| graded NEAR.
- `HOLD_TICKS`, 20: ticks spent in RESULT before returning to IDLE (≥1).
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse, begin round.
- `hit`  in  1  one-cycle pulse, player stop press.
- `rand_in`  in  7  random value from generator.
- `rng_st`  out  1  generator run enable (1 = shifting).
- `target`  out  7  latched target, 0..99.
- `count`  out  7  current count.
- `hit_value`  out  7  count captured at grading.
- `result`  out  2  0 NONE, 1 WIN, 2 NEAR, 3 MISS.
- `timeout`  out  1  last MISS caused by count overrun.
- `score`  out  8  accumulated score, saturating.
- `round_done`  out  1  one-cycle pulse on RESULT entry.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Reset values:
  - `rng_st`=1, state IDLE.
  - `target`, `count`, `hit_value`, `score` = 0.
  - `result`=NONE, `timeout`=0, `round_done`=0, `busy`=0.
  - Prescaler = 0.
- States: IDLE → LOAD → COUNT → RESULT → IDLE.
- IDLE:
  - `rng_st`=1.
  - On `start`: go to LOAD, `rng_st`←0, `result`←NONE, `timeout`←0.
  - `hit` is ignored.
- LOAD (exactly 1 cycle):
  - `target` ← `rand_in` if `rand_in` < 100, else `rand_in`−100.
  - `count`←0, prescaler←0, go to COUNT.
- COUNT:
  - Prescaler counts 0..TICK_DIV−1; the tick fires on the wrap.
  - On tick: `count`+1.
  - If a tick arrives with `count`==MAX_COUNT: `hit_value`←MAX_COUNT, `result`←MISS, `timeout`←1, go to RESULT.
  - On `hit`: `hit_value`←`count`, d=|`count`−`target`| (8-bit unsigned compare).
    - d=0: WIN, score+2.
    - d≤TOL: NEAR, score+1.
    - Otherwise: MISS, no score change.
    - Then go to RESULT.
  - `start` is ignored.
- RESULT:
  - `round_done`=1 in the first cycle only.
  - Stay HOLD_TICKS ticks (prescaler keeps running), then go to IDLE with `rng_st`←1.
  - `start` and `hit` are ignored.
  - `result`, `hit_value` and `target` hold until the next LOAD.
- Score arithmetic: 9-bit sum clamped to 255.

## Timing
- `start` sampled at edge E0: `rng_st`=0 after E0. The generator's last update happens at E0, so `rand_in` is stable from E0.
- `target` is valid after E1; COUNT begins after E1 with `count`=0.
- First increment occurs TICK_DIV cycles after COUNT entry.
- Hit and tick in the same cycle: hit wins, graded against the pre-increment `count`, no increment.
- Hit and timeout tick in the same cycle: graded as hit.
- Hit graded at edge Eh: `result`, `hit_value`, `score` and `round_done` are all valid after Eh.
- `rst` in any state: next cycle matches reset values exactly, including `score`=0 and `rng_st`=1.
- `rst` has priority over `start`/`hit`.

## Structure
- Package `count_game_pkg`:
  - State enum.
  - Result codes (NONE, WIN, NEAR, MISS).
  - Score increments (WIN_PTS=2, NEAR_PTS=1).
  - Constant TARGET_RANGE=100.
- One sub-module `tick_gen` (prescaler, parameter TICK_DIV, inputs `clk`/`rst`/`clr`, output `tick`).
- The FSM, grading and score live in the top.

## Test plan
Parameters for all scenarios: TICK_DIV=4, HOLD_TICKS=2, TOL=2.
- Reset: `rst` high 2 cycles mid-COUNT → next cycle `rng_st`=1, `busy`=0, `score`=0, `count`=0, `result`=NONE.
- `rand_in`=42, `start` pulse → `rng_st`=0 after 1 edge, `target`=42 after 2; `hit` at `count`=42 → WIN, `score`=2, `round_done` pulse, `hit_value`=42; IDLE after 8 cycles with `rng_st`=1.
- `rand_in`=115 → `target`=15.
  - `hit` at 17 → NEAR, `score`+1.
  - Next round same target, `hit` at 18 → MISS, `score` unchanged, `timeout`=0.
- No `hit`: `count` reaches 99, next tick → MISS, `timeout`=1, `hit_value`=99.
- Same-cycle `hit`+tick at `count`=41, `target`=42 → NEAR, `hit_value`=41; `start` pulses during COUNT and RESULT have no effect.
- 128 consecutive WIN rounds → `score`=255 after round 128 (254+2 clamps), stays 255 after round 129.

Source files
------------

// File: rtl/count_game_pkg.sv
// Shared types and constants for the counting-game round controller.
package count_game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COUNT  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_WIN  = 2'd1,
    RES_NEAR = 2'd2,
    RES_MISS = 2'd3
  } result_t;

  localparam logic [7:0] WIN_PTS      = 8'd2;
  localparam logic [7:0] NEAR_PTS     = 8'd1;
  localparam logic [6:0] TARGET_RANGE = 7'd100;

  // 9-bit sum clamped to the 8-bit maximum.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Map a 7-bit random value into 0..99 (values 100..127 fold to 0..27).
  function automatic logic [6:0] fold_target(input logic [6:0] r);
    return (r < TARGET_RANGE) ? r : r - TARGET_RANGE;
  endfunction

endpackage

// File: rtl/count_game_ctrl_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 and flags the wrap cycle as a tick.
module tick_gen #(
  parameter int unsigned TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/count_game_ctrl.sv
// Round controller: freezes the RNG, latches a target, runs a prescaled
// count, grades the player's hit and keeps a saturating score.
module count_game_ctrl
  import count_game_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 5_000_000,
  parameter int unsigned MAX_COUNT  = 99,
  parameter int unsigned TOL        = 2,
  parameter int unsigned HOLD_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic [6:0] rand_in,
  output logic       rng_st,
  output logic [6:0] target,
  output logic [6:0] count,
  output logic [6:0] hit_value,
  output logic [1:0] result,
  output logic       timeout,
  output logic [7:0] score,
  output logic       round_done,
  output logic       busy
);

  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam logic [6:0]    MAXC      = 7'(MAX_COUNT);
  localparam logic [7:0]    TOL_D     = 8'(TOL);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

  state_t        state;
  result_t       res_q;
  logic [HW-1:0] hold_cnt;
  logic          tick;
  logic          tick_clr;

  logic [7:0] diff;
  result_t    grade_res;
  logic [7:0] grade_pts;

  assign tick_clr = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign result   = res_q;

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  always_comb begin
    diff      = (count >= target) ? ({1'b0, count} - {1'b0, target})
                                  : ({1'b0, target} - {1'b0, count});
    grade_res = RES_MISS;
    grade_pts = '0;
    if (diff == 8'd0) begin
      grade_res = RES_WIN;
      grade_pts = WIN_PTS;
    end else if (diff <= TOL_D) begin
      grade_res = RES_NEAR;
      grade_pts = NEAR_PTS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rng_st     <= 1'b1;
      target     <= '0;
      count      <= '0;
      hit_value  <= '0;
      res_q      <= RES_NONE;
      timeout    <= 1'b0;
      score      <= '0;
      round_done <= 1'b0;
      hold_cnt   <= '0;
    end else begin
      round_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_LOAD;
            rng_st  <= 1'b0;
            res_q   <= RES_NONE;
            timeout <= 1'b0;
          end
        end
        ST_LOAD: begin
          target <= fold_target(rand_in);
          count  <= '0;
          state  <= ST_COUNT;
        end
        ST_COUNT: begin
          // A hit takes priority over a coincident tick, including the timeout tick.
          if (hit) begin
            hit_value  <= count;
            res_q      <= grade_res;
            score      <= sat_add(score, grade_pts);
            state      <= ST_RESULT;
            round_done <= 1'b1;
            hold_cnt   <= '0;
          end else if (tick) begin
            if (count == MAXC) begin
              hit_value  <= MAXC;
              res_q      <= RES_MISS;
              timeout    <= 1'b1;
              state      <= ST_RESULT;
              round_done <= 1'b1;
              hold_cnt   <= '0;
            end else begin
              count <= count + 7'd1;
            end
          end
        end
        ST_RESULT: begin
          if (tick) begin
            if (hold_cnt == HOLD_LAST) begin
              state  <= ST_IDLE;
              rng_st <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_game_ctrl.sv
// Self-checking bench for count_game_ctrl with a round-level reference model.
module tb_count_game_ctrl;

  localparam int TD   = 4;
  localparam int MAXC = 99;
  localparam int TOLV = 2;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst, start, hit;
  logic [6:0] rand_in;
  logic       rng_st, timeout, round_done, busy;
  logic [6:0] target, count, hit_value;
  logic [1:0] result;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;
  int model_score = 0;

  count_game_ctrl #(
    .TICK_DIV  (TD),
    .MAX_COUNT (MAXC),
    .TOL       (TOLV),
    .HOLD_TICKS(HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hit       (hit),
    .rand_in   (rand_in),
    .rng_st    (rng_st),
    .target    (target),
    .count     (count),
    .hit_value (hit_value),
    .result    (result),
    .timeout   (timeout),
    .score     (score),
    .round_done(round_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full round. The hit is sampled while the count shows hc, ph cycles
  // after hc appeared (ph=TD-1 lands on the same edge as the next tick).
  task automatic run_round(input int r, input bit do_hit, input int hc,
                           input int ph, input bit noise);
    int tgt, tt, er, idle_off, gv, d, pts, exp_res, exp_to;
    tgt = r % 100;
    rand_in = 7'(r);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("rng_st_after_start", rng_st, 0);
    chk("busy_after_start", busy, 1);
    step();
    chk("target_latched", target, tgt);
    chk("count_at_entry", count, 0);

    tt = do_hit ? (hc * TD + ph) : ((MAXC + 1) * TD - 1);
    for (int t = 0; t < tt; t++) begin
      if (noise && t == 5) begin
        start = 1'b1;
        rand_in = 7'($urandom);
      end
      step();
      start = 1'b0;
      chk("count_progress", count, (t + 1) / TD);
    end
    if (noise) chk("target_stable_in_count", target, tgt);

    hit = do_hit;
    step();
    hit = 1'b0;
    er = tt + 1;

    if (do_hit) begin
      gv = hc;
      d = (hc > tgt) ? hc - tgt : tgt - hc;
      if (d == 0)         begin exp_res = 1; pts = 2; end
      else if (d <= TOLV) begin exp_res = 2; pts = 1; end
      else                begin exp_res = 3; pts = 0; end
      exp_to = 0;
    end else begin
      gv = MAXC; exp_res = 3; pts = 0; exp_to = 1;
    end
    model_score = (model_score + pts > 255) ? 255 : model_score + pts;

    chk("result_graded", result, exp_res);
    chk("hit_value", hit_value, gv);
    chk("score_after_grade", score, model_score);
    chk("round_done_pulse", round_done, 1);
    chk("timeout_flag", timeout, exp_to);
    chk("busy_in_result", busy, 1);

    // Hold lasts until the HOLD-th prescaler wrap after RESULT entry.
    idle_off = (er / TD + HOLD) * TD;
    for (int e = er + 1; e <= idle_off; e++) begin
      if (noise) begin start = 1'b1; hit = 1'b1; end
      step();
      if (e < idle_off) begin
        chk("busy_hold", busy, 1);
        chk("round_done_single", round_done, 0);
        chk("result_hold", result, exp_res);
      end
    end
    start = 1'b0;
    hit = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_rng_st", rng_st, 1);
    chk("idle_result_kept", result, exp_res);
    chk("idle_hit_value_kept", hit_value, gv);
    chk("idle_target_kept", target, tgt);
    chk("idle_score", score, model_score);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_score = 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_rng_st"}, rng_st, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_target"}, target, 0);
    chk({tag, "_hit_value"}, hit_value, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_round_done"}, round_done, 0);
  endtask

  initial begin
    int r, tg, hc;
    rst = 1'b0; start = 1'b0; hit = 1'b0; rand_in = '0;
    do_reset();
    check_reset_state("reset_initial");

    // hit while idle is ignored
    hit = 1'b1;
    step();
    hit = 1'b0;
    chk("idle_hit_ignored_busy", busy, 0);
    chk("idle_hit_ignored_score", score, 0);

    run_round(42, 1'b1, 42, TD - 1, 1'b0);
    run_round(115, 1'b1, 17, 0, 1'b0);
    run_round(115, 1'b1, 18, 1, 1'b0);
    run_round(7, 1'b0, 0, 0, 1'b0);
    run_round(42, 1'b1, 41, TD - 1, 1'b1);
    run_round(127, 1'b1, 99, TD - 1, 1'b0);

    // reset mid-COUNT, with start asserted alongside
    rand_in = 7'd60;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    start = 1'b1;
    hit = 1'b1;
    step();
    step();
    rst = 1'b0;
    start = 1'b0;
    hit = 1'b0;
    model_score = 0;
    check_reset_state("reset_mid_count");

    for (int n = 0; n < 12; n++) begin
      r  = int'($urandom_range(0, 127));
      tg = r % 100;
      hc = tg + int'($urandom_range(0, 8)) - 4;
      if (hc < 0) hc = 0;
      if (hc > MAXC) hc = MAXC;
      run_round(r, 1'b1, hc, int'($urandom_range(0, TD - 1)), n[0]);
    end

    do_reset();
    for (int n = 1; n <= 129; n++) begin
      r = int'($urandom_range(0, 12));
      if (n[2]) r = r + 100;
      run_round(r, 1'b1, r % 100, int'($urandom_range(0, TD - 1)), 1'b0);
      if (n == 127) chk("score_before_clamp", score, 254);
      if (n == 128) chk("score_clamped", score, 255);
      if (n == 129) chk("score_stays_max", score, 255);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
